// File: rtl/fir_out_shaper.sv
// Output shaper: round/shift/saturate a wide signed FIR result into a small FIFO drained by ready/valid.
// Latency: one cycle from push to out_valid/out_data when the FIFO is empty; shaping itself is combinational.
// Backpressure: in_ready drops when the FIFO is full (no pass-through); out_data holds while out_ready is low.
// Optional macro FIR_SHAPER_PEAK_EN adds the 'peak' output (max |shaped value| since reset/sat_clr).

// Generic single-clock FIFO with a registered memory and an explicit occupancy counter.
// Latency: a push is visible at head_dat on the next cycle; head_dat reads the entry at the read pointer.
// Backpressure: push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (cnt == LW'(DEPTH));
  assign empty    = (cnt == '0);
  assign level    = cnt;
  assign head_dat = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

module fir_out_shaper #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     sat_clr,
  output logic                     sat_flag,
  output logic [7:0]               sat_cnt,
`ifdef FIR_SHAPER_PEAK_EN
  output logic [OUT_W-2:0]         peak,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  // Rounding offset and clamp limits, all in the IN_W+1 bit working width.
  localparam logic signed [IN_W:0]    RND  = (IN_W+1)'(2**(SHIFT-1));
  localparam logic signed [IN_W:0]    MAXR = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0]    MINR = (IN_W+1)'(-(2**(OUT_W-1)));
  localparam logic signed [OUT_W-1:0] MAXO = OUT_W'(2**(OUT_W-1) - 1);
  localparam logic signed [OUT_W-1:0] MINO = OUT_W'(-(2**(OUT_W-1)));

  logic signed [IN_W:0]    t;
  logic signed [IN_W:0]    r;
  logic signed [OUT_W-1:0] shaped;
  logic                    sat;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;

  // Round half toward +inf, arithmetic shift, then clamp to the output range.
  always_comb begin
    t      = $signed({in_data[IN_W-1], in_data}) + RND;
    r      = t >>> SHIFT;
    shaped = r[OUT_W-1:0];
    sat    = 1'b0;
    if (r > MAXR) begin
      shaped = MAXO;
      sat    = 1'b1;
    end else if (r < MINR) begin
      shaped = MINO;
      sat    = 1'b1;
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (shaped),
    .pop      (pop),
    .head_dat (out_data),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Saturation statistics: only accepted samples count; clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (sat_clr) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (push && sat) begin
      sat_flag <= 1'b1;
      if (sat_cnt != 8'hFF) begin
        sat_cnt <= sat_cnt + 8'd1;
      end
    end
  end

`ifdef FIR_SHAPER_PEAK_EN
  logic signed [OUT_W-1:0] neg_shaped;
  logic [OUT_W-2:0]        abs_shaped;

  // Magnitude of the shaped sample; the most negative code clips to the positive maximum.
  always_comb begin
    neg_shaped = -shaped;
    abs_shaped = shaped[OUT_W-2:0];
    if (shaped[OUT_W-1]) begin
      abs_shaped = (shaped == MINO) ? '1 : neg_shaped[OUT_W-2:0];
    end
  end

  // Running maximum of accepted sample magnitudes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (sat_clr) begin
      peak <= '0;
    end else if (push && (abs_shaped > peak)) begin
      peak <= abs_shaped;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_shaper.sv
// Randomized and directed bench for fir_out_shaper against a queue-based reference model.
// Latency: model advances one step per clock; DUT outputs are compared on the falling edge.
// Backpressure: out_ready is randomized; the model applies the full/empty rules arithmetically.
module tb_fir_out_shaper;

  localparam int IN_W  = 14;
  localparam int OUT_W = 8;
  localparam int SHIFT = 6;
  localparam int DEPTH = 4;
  localparam int MAXO  = (1 << (OUT_W-1)) - 1;
  localparam int MINO  = -(1 << (OUT_W-1));

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic [IN_W-1:0]        in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [OUT_W-1:0]       out_data;
  logic                   out_ready;
  logic                   sat_clr;
  logic                   sat_flag;
  logic [7:0]             sat_cnt;
  logic [$clog2(DEPTH):0] level;
`ifdef FIR_SHAPER_PEAK_EN
  logic [OUT_W-2:0]       peak;
`endif

  int n_cmp;
  int n_bad;

  // Reference model state
  int q[$];
  int m_cnt;
  bit m_flag;
  int m_peak;

  fir_out_shaper #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_flag  (sat_flag),
    .sat_cnt   (sat_cnt),
`ifdef FIR_SHAPER_PEAK_EN
    .peak      (peak),
`endif
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp to the output range.
  function automatic int ref_shape(input int x, output bit s);
    int v;
    int d;
    int res;
    d = 1 << SHIFT;
    v = x + (d / 2);
    if (v >= 0) res = v / d;
    else        res = -((-v + d - 1) / d);
    s = 1'b0;
    if (res > MAXO) begin
      res = MAXO;
      s   = 1'b1;
    end else if (res < MINO) begin
      res = MINO;
      s   = 1'b1;
    end
    return res;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_flag = 1'b0;
    m_peak = 0;
  endtask

  task automatic compare_all();
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
    chk("level", int'(level), q.size());
    chk("sat_cnt", int'(sat_cnt), m_cnt);
    chk("sat_flag", int'(sat_flag), int'(m_flag));
    if (q.size() != 0) chk("out_data", $signed(out_data), q[0]);
`ifdef FIR_SHAPER_PEAK_EN
    chk("peak", int'(peak), m_peak);
`endif
  endtask

  // Advance the model by one clock using the currently driven inputs, then compare.
  task automatic step();
    bit rdy;
    bit do_push;
    bit do_pop;
    bit s;
    int v;
    int mag;
    rdy     = (q.size() != DEPTH);
    do_push = in_valid && rdy;
    do_pop  = (q.size() != 0) && out_ready;
    v       = ref_shape($signed(in_data), s);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(v);
    if (sat_clr) begin
      m_cnt  = 0;
      m_flag = 1'b0;
      m_peak = 0;
    end else if (do_push) begin
      if (s) begin
        m_flag = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      mag = (v < 0) ? -v : v;
      if (mag > MAXO) mag = MAXO;
      if (mag > m_peak) m_peak = mag;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input int d, input bit rdy, input bit clr);
    in_valid  = v;
    in_data   = IN_W'(d);
    out_ready = rdy;
    sat_clr   = clr;
  endtask

  initial begin
    int rounding_in[5];
    int rounding_out[5];
    int d;
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Rounding: each result appears one cycle after its push.
    rounding_in  = '{100, -100, 95, 96, -96};
    rounding_out = '{2, -2, 1, 2, -1};
    for (int i = 0; i < 5; i++) begin
      drive(1, rounding_in[i], 1, 0);
      step();
      chk("round_out", $signed(out_data), rounding_out[i]);
      chk("round_vld", int'(out_valid), 1);
    end
    drive(0, 0, 1, 0);
    step();
    chk("round_sat_cnt", int'(sat_cnt), 0);

    // Saturation at both ends, then clear.
    drive(1, 8191, 1, 0);
    step();
    chk("sat_pos_out", $signed(out_data), 127);
    chk("sat_pos_cnt", int'(sat_cnt), 1);
    chk("sat_pos_flag", int'(sat_flag), 1);
    drive(1, -8192, 1, 0);
    step();
    chk("sat_neg_out", $signed(out_data), -128);
    chk("sat_neg_cnt", int'(sat_cnt), 1);
    drive(1, 8191, 1, 1);
    step();
    chk("clr_prio_cnt", int'(sat_cnt), 0);
    chk("clr_prio_flag", int'(sat_flag), 0);
    drive(0, 0, 1, 0);
    step();

    // Full / backpressure.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 64 * i, 0, 0);
      step();
    end
    chk("full_level", int'(level), 4);
    chk("full_in_ready", int'(in_ready), 0);
    drive(0, 0, 0, 0);
    step();
    chk("bp_hold", $signed(out_data), 1);
    drive(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", $signed(out_data), k);
      step();
    end
    chk("drain_empty", int'(out_valid), 0);

    // Simultaneous push and pop at level 2.
    drive(1, 64, 0, 0);
    step();
    drive(1, 128, 0, 0);
    step();
    chk("sim_level_pre", int'(level), 2);
    chk("sim_head_pre", $signed(out_data), 1);
    drive(1, 384, 1, 0);
    step();
    chk("sim_level", int'(level), 2);
    chk("sim_head", $signed(out_data), 2);
    drive(0, 0, 1, 0);
    step();
    chk("sim_last", $signed(out_data), 6);
    step();

`ifdef FIR_SHAPER_PEAK_EN
    drive(0, 0, 1, 1);
    step();
    drive(1, 10 * 64, 1, 0);
    step();
    chk("peak_10", int'(peak), 10);
    drive(1, -50 * 64, 1, 0);
    step();
    chk("peak_50", int'(peak), 50);
    drive(1, 8191, 1, 0);
    step();
    chk("peak_127", int'(peak), 127);
    drive(0, 0, 1, 1);
    step();
    chk("peak_clr", int'(peak), 0);
`endif

    // Counter saturation, then asynchronous reset mid-stream.
    drive(1, 8191, 1, 0);
    for (int i = 0; i < 300; i++) step();
    chk("cnt_stick", int'(sat_cnt), 255);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_level", int'(level), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_sat_cnt", int'(sat_cnt), 0);
    chk("arst_sat_flag", int'(sat_flag), 0);
    chk("arst_out_data", int'(out_data), 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) d = $urandom_range(8150, 8191) * (($urandom_range(0, 1) == 0) ? 1 : -1);
      else d = int'($urandom_range(0, 16383)) - 8192;
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
